// File: rtl/write_back_register_file_pkg.sv
// Shared write-back definitions.
// Purpose : widths and write-back source selector encodings used by the
//           EX/MEM stage, the decoder, the forwarding unit and the WB stage.
package write_back_register_file_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    // Write-back source selector.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_IMM  = 2'b10,
        WB_SEL_PORT = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/write_back_register_file_mux.sv
// write_back_mux
// Purpose : pure combinational 4:1 write-back source selector. The forwarding
//           unit uses the same block.
// Ports   : i_ex_result, i_memory_data, i_immediate, i_port - candidate values
//           i_wb_selector - source select (WB_SEL_*)
//           o_wb_data     - selected value
module write_back_mux
    import write_back_register_file_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic [DATA_W-1:0] i_memory_data,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic [DATA_W-1:0] i_port,
    input  logic [1:0]        i_wb_selector,
    output logic [DATA_W-1:0] o_wb_data
);

    always_comb begin
        o_wb_data = i_ex_result;
        case (wb_sel_e'(i_wb_selector))
            WB_SEL_ALU:  o_wb_data = i_ex_result;
            WB_SEL_MEM:  o_wb_data = i_memory_data;
            WB_SEL_IMM:  o_wb_data = i_immediate;
            WB_SEL_PORT: o_wb_data = i_port;
            default:     o_wb_data = i_ex_result;
        endcase
    end

endmodule

// File: rtl/write_back_register_file.sv
// write_back_register_file
// Purpose : consumer end of the EX/MEM->WB buffer. Selects the write-back
//           value, commits it into an 8x16 register file and serves two
//           combinational read ports with same-cycle write-through bypass.
// Ports   : i_clk, i_reset_n (synchronous, active-low)
//           i_ex_result/i_memory_data/i_immediate/i_port - WB candidates
//           i_wb_selector, i_write_back, i_write_addr     - commit control
//           i_read_addr_a/b -> o_read_data_a/b            - decode read ports
//           o_wb_data/o_wb_addr/o_wb_en                   - forwarding view
module write_back_register_file
    import write_back_register_file_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic [DATA_W-1:0] i_memory_data,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic [DATA_W-1:0] i_port,
    input  logic [1:0]        i_wb_selector,
    input  logic              i_write_back,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [ADDR_W-1:0] i_read_addr_a,
    input  logic [ADDR_W-1:0] i_read_addr_b,
    output logic [DATA_W-1:0] o_read_data_a,
    output logic [DATA_W-1:0] o_read_data_b,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic              o_wb_en
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    write_back_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .i_ex_result   (i_ex_result),
        .i_memory_data (i_memory_data),
        .i_immediate   (i_immediate),
        .i_port        (i_port),
        .i_wb_selector (i_wb_selector),
        .o_wb_data     (o_wb_data)
    );

    assign o_wb_addr = i_write_addr;
    // Gating with reset keeps the forwarding unit and the bypass from
    // acting on a write that the register file is about to drop.
    assign o_wb_en   = i_write_back & i_reset_n;

    // Storage: reset wins over a coincident write. No hardwired R0.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            regs <= '0;
        end else if (i_write_back) begin
            regs[i_write_addr] <= o_wb_data;
        end
    end

    // Read ports: forced to zero in reset, otherwise write-through bypass
    // so decode sees the value being committed this cycle.
    always_comb begin
        o_read_data_a = regs[i_read_addr_a];
        o_read_data_b = regs[i_read_addr_b];
        if (!i_reset_n) begin
            o_read_data_a = '0;
            o_read_data_b = '0;
        end else begin
            if (o_wb_en && (i_read_addr_a == i_write_addr)) o_read_data_a = o_wb_data;
            if (o_wb_en && (i_read_addr_b == i_write_addr)) o_read_data_b = o_wb_data;
        end
    end

endmodule

// File: tb/tb_write_back_register_file.sv
// Directed testbench for write_back_register_file.
module tb_write_back_register_file;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_ex_result, i_memory_data, i_immediate, i_port;
    logic [1:0]  i_wb_selector;
    logic        i_write_back;
    logic [2:0]  i_write_addr, i_read_addr_a, i_read_addr_b;
    logic [15:0] o_read_data_a, o_read_data_b, o_wb_data;
    logic [2:0]  o_wb_addr;
    logic        o_wb_en;

    int errs = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    write_back_register_file dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_ex_result   (i_ex_result),
        .i_memory_data (i_memory_data),
        .i_immediate   (i_immediate),
        .i_port        (i_port),
        .i_wb_selector (i_wb_selector),
        .i_write_back  (i_write_back),
        .i_write_addr  (i_write_addr),
        .i_read_addr_a (i_read_addr_a),
        .i_read_addr_b (i_read_addr_b),
        .o_read_data_a (o_read_data_a),
        .o_read_data_b (o_read_data_b),
        .o_wb_data     (o_wb_data),
        .o_wb_addr     (o_wb_addr),
        .o_wb_en       (o_wb_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    logic [15:0] sweep_exp [4];

    initial begin
        sweep_exp[0] = 16'h1111;
        sweep_exp[1] = 16'h2222;
        sweep_exp[2] = 16'h3333;
        sweep_exp[3] = 16'h4444;

        i_reset_n     = 1'b0;
        i_ex_result   = '0;
        i_memory_data = '0;
        i_immediate   = '0;
        i_port        = '0;
        i_wb_selector = 2'b00;
        i_write_back  = 1'b0;
        i_write_addr  = '0;
        i_read_addr_a = '0;
        i_read_addr_b = '0;

        // Reset held for two edges, then every address reads zero.
        tick();
        chk("rst_hold_rd_a", {16'h0, o_read_data_a}, 32'h0);
        chk("rst_hold_wb_en", {31'h0, o_wb_en}, 32'h0);
        tick();
        i_reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_read_addr_a = 3'(i);
            i_read_addr_b = 3'(7 - i);
            #1;
            chk($sformatf("rst_rd_a%0d", i), {16'h0, o_read_data_a}, 32'h0);
            chk($sformatf("rst_rd_b%0d", 7 - i), {16'h0, o_read_data_b}, 32'h0);
        end

        // Selector sweep into R1..R4.
        i_ex_result   = 16'h1111;
        i_memory_data = 16'h2222;
        i_immediate   = 16'h3333;
        i_port        = 16'h4444;
        i_read_addr_a = 3'd0;
        i_read_addr_b = 3'd0;
        for (int k = 0; k < 4; k++) begin
            i_wb_selector = 2'(k);
            i_write_addr  = 3'(k + 1);
            i_write_back  = 1'b1;
            #1;
            chk($sformatf("sel%0d_wb_data", k), {16'h0, o_wb_data}, {16'h0, sweep_exp[k]});
            chk($sformatf("sel%0d_wb_addr", k), {29'h0, o_wb_addr}, k + 1);
            chk($sformatf("sel%0d_wb_en", k), {31'h0, o_wb_en}, 32'h1);
            tick();
        end
        i_write_back = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_read_addr_a = 3'(k + 1);
            i_read_addr_b = 3'(4 - k);
            #1;
            chk($sformatf("sweep_rd_a_r%0d", k + 1), {16'h0, o_read_data_a}, {16'h0, sweep_exp[k]});
            chk($sformatf("sweep_rd_b_r%0d", 4 - k), {16'h0, o_read_data_b}, {16'h0, sweep_exp[3 - k]});
        end

        // Bypass: both ports see the pending write to R5 before the edge.
        i_immediate   = 16'hBEEF;
        i_wb_selector = 2'b10;
        i_write_addr  = 3'd5;
        i_write_back  = 1'b1;
        i_read_addr_a = 3'd5;
        i_read_addr_b = 3'd5;
        #1;
        chk("byp_a", {16'h0, o_read_data_a}, 32'hBEEF);
        chk("byp_b", {16'h0, o_read_data_b}, 32'hBEEF);
        tick();
        i_write_back = 1'b0;
        i_immediate  = 16'h0000;
        #1;
        chk("byp_stored_a", {16'h0, o_read_data_a}, 32'hBEEF);
        chk("byp_stored_b", {16'h0, o_read_data_b}, 32'hBEEF);

        // Write disable: R6 untouched, no bypass, wb_en low.
        i_wb_selector = 2'b00;
        i_ex_result   = 16'hDEAD;
        i_write_addr  = 3'd6;
        i_read_addr_a = 3'd6;
        i_read_addr_b = 3'd4;
        #1;
        chk("wdis_wb_en", {31'h0, o_wb_en}, 32'h0);
        chk("wdis_wb_data", {16'h0, o_wb_data}, 32'hDEAD);
        chk("wdis_rd_a", {16'h0, o_read_data_a}, 32'h0);
        tick();
        chk("wdis_after_a", {16'h0, o_read_data_a}, 32'h0);
        chk("wdis_after_b", {16'h0, o_read_data_b}, 32'h4444);

        // Reset collision on R7.
        i_ex_result   = 16'h00AA;
        i_write_addr  = 3'd7;
        i_write_back  = 1'b1;
        tick();
        i_write_back  = 1'b0;
        i_read_addr_a = 3'd7;
        i_read_addr_b = 3'd7;
        #1;
        chk("col_pre_r7", {16'h0, o_read_data_a}, 32'h00AA);
        i_reset_n    = 1'b0;
        i_ex_result  = 16'h5555;
        i_write_back = 1'b1;
        #1;
        chk("col_rst_rd_a", {16'h0, o_read_data_a}, 32'h0);
        chk("col_rst_rd_b", {16'h0, o_read_data_b}, 32'h0);
        chk("col_rst_wb_en", {31'h0, o_wb_en}, 32'h0);
        chk("col_rst_wb_data", {16'h0, o_wb_data}, 32'h5555);
        tick();
        i_reset_n    = 1'b1;
        i_write_back = 1'b0;
        #1;
        chk("col_post_r7", {16'h0, o_read_data_a}, 32'h0);
        i_read_addr_b = 3'd5;
        #1;
        chk("col_post_r5", {16'h0, o_read_data_b}, 32'h0);

        // Back-to-back writes to R2; port B watches an unwritten R3.
        i_wb_selector = 2'b00;
        i_write_addr  = 3'd2;
        i_read_addr_a = 3'd2;
        i_read_addr_b = 3'd3;
        i_ex_result   = 16'h0001;
        i_write_back  = 1'b1;
        #1;
        chk("b2b_c1_a", {16'h0, o_read_data_a}, 32'h0001);
        chk("b2b_c1_b", {16'h0, o_read_data_b}, 32'h0);
        tick();
        i_ex_result = 16'h0002;
        #1;
        chk("b2b_c2_a", {16'h0, o_read_data_a}, 32'h0002);
        tick();
        i_write_back = 1'b0;
        i_ex_result  = 16'h0000;
        #1;
        chk("b2b_stored", {16'h0, o_read_data_a}, 32'h0002);

        // R0 is an ordinary register.
        i_wb_selector = 2'b11;
        i_port        = 16'hA5C3;
        i_write_addr  = 3'd0;
        i_write_back  = 1'b1;
        tick();
        i_write_back  = 1'b0;
        i_port        = 16'h0000;
        i_read_addr_a = 3'd0;
        i_read_addr_b = 3'd2;
        #1;
        chk("r0_write", {16'h0, o_read_data_a}, 32'hA5C3);
        chk("r0_other", {16'h0, o_read_data_b}, 32'h0002);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/write_back_register_file.md
Name: write_back_register_file

Overview:
- Consumer end of the EX/MEM→WB pipeline buffer.
- Takes the buffered ex result, memory data, immediate and input-port value, and selects the write-back value with the 2-bit selector.
- Commits the selected value into an 8×16 general-purpose register file.
- Serves the decode stage through two combinational read ports with same-cycle write bypass, and exposes the committed write to the forwarding unit.

Parameters:
- DATA_W, 16, register and operand width
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count (2**ADDR_W)

Ports:
- i_clk  in  1  rising-edge clock
- i_reset_n  in  1  synchronous active-low reset
- i_ex_result  in  DATA_W  buffered ALU result
- i_memory_data  in  DATA_W  buffered memory read data
- i_immediate  in  DATA_W  buffered immediate
- i_port  in  DATA_W  buffered input-port value
- i_wb_selector  in  2  write-back source select
- i_write_back  in  1  write enable
- i_write_addr  in  ADDR_W  destination register
- i_read_addr_a  in  ADDR_W  decode read port A address
- i_read_addr_b  in  ADDR_W  decode read port B address
- o_read_data_a  out  DATA_W  port A data
- o_read_data_b  out  DATA_W  port B data
- o_wb_data  out  DATA_W  selected write-back value (forwarding)
- o_wb_addr  out  ADDR_W  destination register (forwarding)
- o_wb_en  out  1  write-back active this cycle (forwarding)

Behaviour:
- One clock (i_clk); reset is synchronous and active-low (i_reset_n), sampled on the rising edge.
- Selector encoding:
  - 2'b00 → i_ex_result
  - 2'b01 → i_memory_data
  - 2'b10 → i_immediate
  - 2'b11 → i_port
- o_wb_data = selected value, combinational.
- o_wb_addr = i_write_addr, combinational.
- o_wb_en = i_write_back & i_reset_n, combinational.
- Write: on a rising edge with i_reset_n=1 and i_write_back=1, regs[i_write_addr] <= o_wb_data. Latency 1 cycle to storage.
- With i_write_back=0, no register changes regardless of selector or address.
- All registers, including R0, are writable; there is no hardwired zero.
- Read: combinational per port.
  - If o_wb_en=1 and the read address equals i_write_addr, output o_wb_data (write-through bypass).
  - Otherwise output regs[read addr].
  - Both ports bypass independently. Both ports may read the same register.
- Reset: on a rising edge with i_reset_n=0, all NUM_REGS registers are cleared to 0.
  - Reset overrides a simultaneous write; the write is dropped.
  - While i_reset_n=0: o_read_data_a, o_read_data_b and o_wb_en are forced to 0, and bypass is disabled.
  - o_wb_data and o_wb_addr still reflect the inputs (don't-care for consumers since o_wb_en=0).
- Reset mid-stream: a write presented during reset is lost. The first write after deassertion behaves normally.
- Back-to-back writes to the same register: last write wins. Each cycle's read sees that cycle's pending write via bypass.
- No X-propagation from unwritten registers: all storage is defined after reset.

Decomposition:
- Shared package constants: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_IMM=2'b10, WB_SEL_PORT=2'b11. The EX/MEM stage and the decoder use the same constants.
- Sub-module write_back_mux: pure combinational 4:1 selector, reused by the forwarding unit.
- Storage, bypass and reset logic live in the top module.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles, release → reading all 8 addresses on both ports returns 16'h0000.
- Selector sweep:
  - Inputs: ex=16'h1111, mem=16'h2222, imm=16'h3333, port=16'h4444; write R1..R4 with selectors 00, 01, 10, 11 on consecutive cycles.
  - Required: reads return R1=16'h1111, R2=16'h2222, R3=16'h3333, R4=16'h4444.
- Bypass: write R5 ← imm 16'hBEEF with read_addr_a=5 and read_addr_b=5 in the same cycle.
  - Both ports show 16'hBEEF before the edge.
  - After the edge with i_write_back=0, both ports still show 16'hBEEF from storage.
- Write disable: i_write_back=0, selector 00, ex=16'hDEAD, addr=6 → R6 stays 16'h0000; o_wb_en=0.
- Reset collision: R7 holds 16'h00AA; assert i_reset_n=0 with a write of 16'h5555 to R7.
  - R7 reads 16'h0000 after release; o_read_data_a=0 during reset.
- Back-to-back: write R2 ← 16'h0001, then R2 ← 16'h0002 on the next cycle.
  - Port A at addr 2 shows 16'h0001 in cycle 1 and 16'h0002 in cycle 2.
  - Stored value afterwards is 16'h0002.
